jk_bank_sequencer: RTL and testbench
====================================

// Module: jk_bank_sequencer
// PURPOSE
//  Shares one bank of WIDTH JK flip-flops between NREQ requesters.
//  Each requester issues HOLD, RESET, SET or TOGGLE commands with a per-bit mask.
//  A round-robin arbiter picks one requester and drives j/k into the bank for exactly one clock.
//  It then checks the bank's q against the expected next state.
//  Sits between command sources and the jk_flip_flop bank.
// PARAMETERS
//  NREQ   2  number of requesters (2..8)
//  WIDTH  4  number of JK flip-flops in the bank
// PORTS
//  clk        in   1           single system clock, rising edge
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NREQ        requester i has a command pending
//  req_cmd    in   2*NREQ      cmd of requester i at [2i+1:2i] = {j,k}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//  req_mask   in   WIDTH*NREQ  bit mask of requester i at [WIDTH*i +: WIDTH]; 1 = bit affected
//  req_ready  out  NREQ        one-hot accept pulse to the granted requester
//  j_out      out  WIDTH       j inputs of the bank
//  k_out      out  WIDTH       k inputs of the bank
//  q_in       in   WIDTH       q outputs of the bank
//  grant_id   out  3           index of the requester currently being served
//  done       out  1           1-cycle pulse: command completed
//  err        out  1           1-cycle pulse with done: q_in differs from expected
// BEHAVIOUR
//  Reset:
//   - rst=1 at a rising edge forces state IDLE.
//   - Forces req_ready=0, j_out=0, k_out=0, grant_id=0, done=0 and err=0.
//   - Sets the RR pointer last=NREQ-1, so requester 0 has top priority after reset.
//   - Applies mid-operation too: the command in flight is abandoned, with no done and no err.
//  FSM, 3 states, registered outputs:
//   IDLE:
//    - j/k=0.
//    - If any req_valid: pick the first set bit searching last+1, last+2, ... (mod NREQ).
//    - Register its cmd as c and its mask as m; snapshot q_in as q0.
//    - Set grant_id to the winner and last to the winner.
//    - Pulse req_ready[winner] for this cycle (registered, asserted in the cycle the FSM enters DRIVE).
//    - Go to DRIVE.
//   DRIVE (exactly 1 cycle):
//    - j_out = m & {WIDTH{c[1]}}; k_out = m & {WIDTH{c[0]}}.
//    - The bank captures on the edge that ends DRIVE.
//    - Go to SAMPLE.
//   SAMPLE (1 cycle):
//    - j/k=0.
//    - exp = (q0 & ~m) | (m & f(q0)), where f: HOLD q0, RESET 0, SET 1, TOGGLE ~q0.
//    - done=1; err = (q_in != exp).
//    - Go to IDLE.
//  Handshake:
//   - A requester holds req_valid and its cmd/mask stable until it sees req_ready.
//   - req_ready is never asserted to a requester whose valid is low.
//   - Deasserting valid before ready withdraws the request.
//  Throughput:
//   - One command per 3 cycles; done follows the req_ready cycle by 2 cycles.
//   - A requester re-raising valid right after ready waits behind every other pending requester.
//  Boundaries:
//   - mask=0 is a legal no-op; it still takes 3 cycles and reports done.
//   - HOLD (00) drives j=k=0 and must report err=0 on a quiet bank.
//   - Multiple valid in IDLE: exactly one ready; the pointer wraps NREQ-1 -> 0.
//   - Only one requester valid: it is served every 3 cycles; no starvation.
//   - grant_id holds its last value in IDLE when no request is pending.
// TESTING
//  T1 reset:
//   - rst high 2 cycles with req_valid=11.
//   - Expect ready=00, j/k=0, done=0.
//   - After release, req 0 is granted first.
//  T2 set/reset:
//   - Bank q=0000; req0 SET mask=1010 -> j_out=1010, k_out=0000 for 1 cycle; q=1010, done=1, err=0.
//   - Then req1 RESET mask=0010 -> q=1000.
//  T3 toggle/hold:
//   - q=1000; TOGGLE mask=1111 -> q=0111, err=0.
//   - HOLD mask=1111 -> j/k stay 0, q=0111, err=0.
//  T4 round robin:
//   - Both valid continuously -> grants alternate 0,1,0,1.
//   - ready pulses spaced 3 cycles apart; no back-to-back grant to the same id.
//  T5 reset mid-op:
//   - Assert rst during DRIVE -> j/k=0 on the next cycle, no done pulse.
//   - Next grant goes to requester 0.
//  T6 error detect:
//   - Bench forces q_in stuck at 0000 and issues SET mask=0001 -> done=1, err=1.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// Round-robin sequencer that time-shares one bank of JK flip-flops between
// several requesters, drives one command per slot and verifies the bank's response.
module jk_bank_sequencer #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_cmd,
  input  logic [WIDTH*NREQ-1:0]   req_mask,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        j_out,
  output logic [WIDTH-1:0]        k_out,
  input  logic [WIDTH-1:0]        q_in,
  output logic [2:0]              grant_id,
  output logic                    done,
  output logic                    err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DRIVE    = 2'd1;
  localparam logic [1:0] SAMPLE   = 2'd2;
  localparam logic [2:0] LAST_RST = 3'(NREQ - 1);

  logic [1:0]       state_q, state_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       grant_q, grant_d;
  logic [1:0]       c_q, c_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] q0_q, q0_d;
  logic [NREQ-1:0]  ready_q, ready_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             found;
  logic [2:0]       win;
  logic [NREQ-1:0]  win_onehot;
  logic [1:0]       c_sel;
  logic [WIDTH-1:0] m_sel;
  logic [WIDTH-1:0] f_val;
  logic [WIDTH-1:0] exp_q;

  // Search last+1, last+2, ... (mod NREQ); the first valid requester wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] &&
            ((int'(last_q) + off == i) || (int'(last_q) + off == i + NREQ))) begin
          found = 1'b1;
          win   = 3'(i);
        end
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    c_sel      = '0;
    m_sel      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == 3'(i)) begin
        win_onehot[i] = found;
        c_sel         = req_cmd[2*i +: 2];
        m_sel         = req_mask[WIDTH*i +: WIDTH];
      end
    end
  end

  // Expected bank contents: masked bits follow the command, the rest keep q0.
  always_comb begin
    case (c_q)
      2'b00:   f_val = q0_q;
      2'b01:   f_val = '0;
      2'b10:   f_val = '1;
      default: f_val = ~q0_q;
    endcase
    exp_q = (q0_q & ~m_q) | (m_q & f_val);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    c_d     = c_q;
    m_d     = m_q;
    q0_d    = q0_q;
    ready_d = '0;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          c_d     = c_sel;
          m_d     = m_sel;
          q0_d    = q_in;
          grant_d = win;
          last_d  = win;
          ready_d = win_onehot;
          j_d     = m_sel & {WIDTH{c_sel[1]}};
          k_d     = m_sel & {WIDTH{c_sel[0]}};
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = SAMPLE;
      end
      SAMPLE: begin
        done_d  = 1'b1;
        err_d   = (q_in != exp_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      grant_q <= '0;
      c_q     <= '0;
      m_q     <= '0;
      q0_q    <= '0;
      ready_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      c_q     <= c_d;
      m_q     <= m_d;
      q0_q    <= q0_d;
      ready_q <= ready_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = ready_q;
  assign j_out     = j_q;
  assign k_out     = k_q;
  assign grant_id  = grant_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer with a behavioural JK bank on the
// j/k/q loop; a stuck-at-zero override lets the error path be exercised.
module tb_jk_bank_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_cmd;
  logic [7:0] req_mask;
  logic [1:0] req_ready;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic [3:0] q_in;
  logic [2:0] grant_id;
  logic       done;
  logic       err;

  logic [3:0] bank_q;
  logic       bank_clr;
  logic       stuck;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] HOLD   = 2'b00;
  localparam logic [1:0] RESET  = 2'b01;
  localparam logic [1:0] SET    = 2'b10;
  localparam logic [1:0] TOGGLE = 2'b11;

  jk_bank_sequencer #(.NREQ(2), .WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_cmd   (req_cmd),
    .req_mask  (req_mask),
    .req_ready (req_ready),
    .j_out     (j_out),
    .k_out     (k_out),
    .q_in      (q_in),
    .grant_id  (grant_id),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bank of JK flip-flops fed by the sequencer.
  always @(posedge clk) begin
    if (bank_clr) bank_q <= 4'b0000;
    else          bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
  end

  assign q_in = stuck ? 4'b0000 : bank_q;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int id, input logic [1:0] cmd, input logic [3:0] mask, input logic valid);
    req_cmd[2*id +: 2]  = cmd;
    req_mask[4*id +: 4] = mask;
    req_valid[id]       = valid;
  endtask

  // Bounded wait for any ready pulse, sampled on falling edges.
  task automatic waitReady();
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (req_ready == 2'b00 && waited < 8);
  endtask

  task automatic runCommand(input string tag, input int id, input logic [1:0] cmd, input logic [3:0] mask,
                            input logic [3:0] exp_j, input logic [3:0] exp_k,
                            input logic [3:0] exp_q, input logic exp_err);
    applyStimulus(id, cmd, mask, 1'b1);
    waitReady();
    checkOutput({tag, " ready"}, 32'(req_ready), 32'(2'b01 << id));
    checkOutput({tag, " grant_id"}, 32'(grant_id), 32'(id));
    checkOutput({tag, " j_out"}, 32'(j_out), 32'(exp_j));
    checkOutput({tag, " k_out"}, 32'(k_out), 32'(exp_k));
    req_valid[id] = 1'b0;
    @(negedge clk);
    checkOutput({tag, " jk idle"}, 32'({j_out, k_out}), 32'd0);
    checkOutput({tag, " early done"}, 32'(done), 32'd0);
    @(negedge clk);
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, " q"}, 32'(q_in), 32'(exp_q));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_id;
    int pulses;
    int dones;
    int last_cyc;

    // T1: reset with both requesters pending (no-op commands)
    rst       = 1'b1;
    bank_clr  = 1'b1;
    stuck     = 1'b0;
    req_valid = 2'b11;
    req_cmd   = 4'b0000;
    req_mask  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("T1 reset ready", 32'(req_ready), 32'd0);
    checkOutput("T1 reset jk", 32'({j_out, k_out}), 32'd0);
    checkOutput("T1 reset done", 32'(done), 32'd0);
    checkOutput("T1 reset err", 32'(err), 32'd0);
    checkOutput("T1 reset grant", 32'(grant_id), 32'd0);
    rst      = 1'b0;
    bank_clr = 1'b0;
    @(negedge clk);
    checkOutput("T1 first ready", 32'(req_ready), 32'b01);
    checkOutput("T1 first grant", 32'(grant_id), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("T1 mask0 done", 32'(done), 32'd1);
    checkOutput("T1 mask0 err", 32'(err), 32'd0);
    checkOutput("T1 grant held", 32'(grant_id), 32'd0);

    // T2: SET then RESET on a clear bank
    runCommand("T2 set",   0, SET,   4'b1010, 4'b1010, 4'b0000, 4'b1010, 1'b0);
    runCommand("T2 reset", 1, RESET, 4'b0010, 4'b0000, 4'b0010, 4'b1000, 1'b0);

    // T3: TOGGLE then HOLD
    runCommand("T3 toggle", 0, TOGGLE, 4'b1111, 4'b1111, 4'b1111, 4'b0111, 1'b0);
    runCommand("T3 hold",   1, HOLD,   4'b1111, 4'b0000, 4'b0000, 4'b0111, 1'b0);

    // T4: both valid continuously, expect 0,1,0,1 at cycles 1,4,7,10
    applyStimulus(0, HOLD, 4'b0000, 1'b1);
    applyStimulus(1, HOLD, 4'b0000, 1'b1);
    exp_id   = 0;
    pulses   = 0;
    dones    = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      if (done) dones++;
      if (req_ready != 2'b00) begin
        checkOutput("T4 rr order", 32'(req_ready), 32'(2'b01 << exp_id));
        if (pulses > 0) checkOutput("T4 rr spacing", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        pulses++;
        exp_id = 1 - exp_id;
        if (pulses == 4) req_valid = 2'b00;
      end
    end
    checkOutput("T4 grant count", 32'(pulses), 32'd4);
    checkOutput("T4 done count", 32'(dones), 32'd3);
    @(negedge clk);
    checkOutput("T4 last done", 32'(done), 32'd1);
    checkOutput("T4 last err", 32'(err), 32'd0);

    // T5: reset during DRIVE abandons the command
    applyStimulus(1, SET, 4'b1000, 1'b1);
    waitReady();
    checkOutput("T5 ready", 32'(req_ready), 32'b10);
    checkOutput("T5 j_out", 32'(j_out), 32'b1000);
    rst       = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("T5 jk cleared", 32'({j_out, k_out}), 32'd0);
    checkOutput("T5 no done a", 32'(done), 32'd0);
    checkOutput("T5 ready cleared", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("T5 no done b", 32'(done), 32'd0);
    rst = 1'b0;
    applyStimulus(0, RESET, 4'b1111, 1'b1);
    applyStimulus(1, HOLD,  4'b0000, 1'b1);
    waitReady();
    checkOutput("T5 regrant", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("T5 regrant done", 32'(done), 32'd1);
    checkOutput("T5 regrant err", 32'(err), 32'd0);
    checkOutput("T5 regrant q", 32'(q_in), 32'b0000);

    // T6: stuck bank must flag an error
    stuck = 1'b1;
    runCommand("T6 stuck", 0, SET, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    stuck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
